mult_div_unit: RTL

Multi-cycle multiply/divide unit in the E stage, holding the architectural HI/LO registers for mult, multu, div, divu, mthi, mtlo; mfhi/mflo read `hi`/`lo` directly. It is the responder to the hazard unit's stall logic. The E stage issues a one-cycle `start` with an opcode. The unit raises `busy` for a fixed latency. The hazard unit holds any MDU-class instruction in D while `start | busy` is high.

---
 rtl/mult_div_unit_if.sv | 13 +
 rtl/mult_div_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdu_op, a, b, input busy, hi, lo);
  modport slave  (input start, mdu_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at issue
// and committed after a fixed architectural latency.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave mdu
);
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DW-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]    res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  // Datapath: full-width products and sign-magnitude division
  logic [2*DW-1:0] prod_s, prod_u;
  logic [DW-1:0]   a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic            div_zero;

  assign prod_s   = {{DW{mdu.a[DW-1]}}, mdu.a} * {{DW{mdu.b[DW-1]}}, mdu.b};
  assign prod_u   = {{DW{1'b0}}, mdu.a} * {{DW{1'b0}}, mdu.b};
  assign div_zero = (mdu.b == '0);

  // Magnitudes keep 0x80000000 / -1 well defined (wraps back to 0x80000000)
  assign a_mag = mdu.a[DW-1] ? (~mdu.a + DW'(1)) : mdu.a;
  assign b_mag = mdu.b[DW-1] ? (~mdu.b + DW'(1)) : mdu.b;
  assign q_mag = div_zero ? '0 : (a_mag / b_mag);
  assign r_mag = div_zero ? '0 : (a_mag % b_mag);
  assign q_s   = (mdu.a[DW-1] ^ mdu.b[DW-1]) ? (~q_mag + DW'(1)) : q_mag;
  assign r_s   = mdu.a[DW-1] ? (~r_mag + DW'(1)) : r_mag;
  assign q_u   = div_zero ? '0 : (mdu.a / mdu.b);
  assign r_u   = div_zero ? '0 : (mdu.a % mdu.b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      IDLE: begin
        if (mdu.start) begin
          case (mdu.mdu_op)
            OP_MULT, OP_MULTU: begin
              {res_hi_d, res_lo_d} = (mdu.mdu_op == OP_MULT) ? prod_s : prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero commits the current HI/LO back unchanged
              if (div_zero) begin
                res_hi_d = hi_q;
                res_lo_d = lo_q;
              end else if (mdu.mdu_op == OP_DIV) begin
                res_hi_d = r_s;
                res_lo_d = q_s;
              end else begin
                res_hi_d = r_u;
                res_lo_d = q_u;
              end
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = mdu.a;
            OP_MTLO: lo_d = mdu.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mdu.busy = busy_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;
endmodule
